ysyx_23060077_icache_rd_responder: RTL and testbench



---
 rtl/ysyx_23060077_icache_rd_if.sv | 25 ++
 rtl/ysyx_23060077_icache_rd_responder.sv | 120 ++++++++++++
 tb/tb_ysyx_23060077_icache_rd_responder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060077_icache_rd_if.sv
// Instruction-fetch read bus between the ICache (master) and the memory-side
// responder (slave): one request with a burst length, answered by a stream of
// strobed data beats with a final-beat marker.
interface ysyx_23060077_icache_rd_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;

  modport master (
    output req_valid, req_addr, req_len,
    input  rsp_ready, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_addr, req_len,
    output rsp_ready, rsp_data, rsp_last
  );
endinterface

// File: rtl/ysyx_23060077_icache_rd_responder.sv
// Fetch-side memory responder: accepts a read request, waits a fixed access
// latency, then streams len+1 consecutive words from an internal memory,
// wrapping at the end of the array. A preload port fills the memory.
module ysyx_23060077_icache_rd_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  ysyx_23060077_icache_rd_if.slave bus,
  output logic                  busy_o,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_t;

  state_t                 state;
  logic [DEPTH_LOG2-1:0]  ptr;
  logic [LEN_WIDTH-1:0]   beats_left;
  logic [3:0]             lat_cnt;
  logic                   rsp_ready_q;
  logic                   rsp_last_q;
  logic [DATA_WIDTH-1:0]  rsp_data_q;
  logic                   busy_q;

  logic [DATA_WIDTH-1:0]  mem [2**DEPTH_LOG2];

  // Only the word-index bits of the byte address matter; the rest alias.
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   unused_addr_bits;
  assign req_addr         = bus.req_addr;
  assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:DEPTH_LOG2+2], req_addr[1:0]};

  // Preload port: one write per cycle, independent of the FSM.
  // NOTE: the memory array has no reset; clearing it would turn a RAM into a
  // huge flop bank, and its content is undefined until preloaded anyway.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Request / latency / burst sequencing with registered beat outputs.
  // NOTE: sequential state uses non-blocking assignments so that every read
  // of mem[ptr] here sees the pre-edge value, even when the preload port
  // writes the same word on the same edge (old data wins).
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      beats_left  <= '0;
      lat_cnt     <= '0;
      rsp_ready_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rsp_ready_q <= 1'b0;
          rsp_last_q  <= 1'b0;
          rsp_data_q  <= '0;
          if (bus.req_valid) begin
            ptr        <= req_addr[DEPTH_LOG2+1:2];
            beats_left <= bus.req_len;
            lat_cnt    <= 4'(LATENCY - 1);
            busy_q     <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            // First beat is presented in the cycle the FSM enters BURST.
            rsp_ready_q <= 1'b1;
            rsp_data_q  <= mem[ptr];
            rsp_last_q  <= (beats_left == '0);
            ptr         <= ptr + DEPTH_LOG2'(1);
            state       <= BURST;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        BURST: begin
          if (beats_left == '0) begin
            // The beat on the outputs now is the last one; close the burst.
            rsp_ready_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end else begin
            rsp_ready_q <= 1'b1;
            rsp_data_q  <= mem[ptr];
            rsp_last_q  <= (beats_left == LEN_WIDTH'(1));
            beats_left  <= beats_left - LEN_WIDTH'(1);
            ptr         <= ptr + DEPTH_LOG2'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_ready = rsp_ready_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_ysyx_23060077_icache_rd_responder.sv
// Bench for the fetch-side read responder: directed scenarios followed by
// random bursts, each beat compared against an array model of the memory
// and the cycle arithmetic of the transaction timing.
module tb_ysyx_23060077_icache_rd_responder;

  localparam int L     = 2;
  localparam int DEPTH = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        busy_o;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  logic [31:0] model_mem [DEPTH];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  always #5 clock = ~clock;

  ysyx_23060077_icache_rd_if bus ();

  ysyx_23060077_icache_rd_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .LEN_WIDTH  (8),
    .DEPTH_LOG2 (10),
    .LATENCY    (L)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .busy_o    (busy_o),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Advance to the middle of the next cycle; a write presented last cycle has
  // landed in memory by now, so the model takes it too.
  task automatic next_cycle();
    @(negedge clock);
    if (wr_en) model_mem[wr_addr] = wr_data;
    wr_en = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(bus.rsp_ready), 32'd0);
    check({tag, "_last"},  32'(bus.rsp_last),  32'd0);
    check({tag, "_data"},  bus.rsp_data,       32'd0);
    check({tag, "_busy"},  32'(busy_o),        32'd0);
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = 10'(a);
    wr_data = d;
    next_cycle();
  endtask

  // One full transaction, called in the middle of the cycle that becomes
  // cycle 0. coll_beat >= 0 writes 0x55 to that beat's word while the beat is
  // on the outputs. gap = idle cycles after the return-to-idle cycle.
  task automatic do_txn(input logic [31:0] addr, input int len, input int coll_beat, input int gap);
    int word;
    int last_c;
    int k;
    word   = int'(addr[11:2]);
    last_c = L + 1 + len;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = 8'(len);
    check("c0_busy", 32'(busy_o), 32'd0);
    for (int c = 1; c <= last_c; c++) begin
      next_cycle();
      k = c - (L + 1);
      check("busy",  32'(busy_o),        32'd1);
      check("ready", 32'(bus.rsp_ready), 32'(c >= L + 1));
      check("last",  32'(bus.rsp_last),  32'(c == last_c));
      check("data",  bus.rsp_data, (k >= 0) ? model_mem[(word + k) % DEPTH] : 32'd0);
      if (k >= 0 && k == coll_beat) begin
        wr_en   = 1'b1;
        wr_addr = 10'((word + k) % DEPTH);
        wr_data = 32'h55;
      end
    end
    bus.req_valid = 1'b0;
    next_cycle();
    check_idle("ret");
    for (int g = 0; g < gap; g++) begin
      next_cycle();
      check_idle("gap");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] addr;
    int len;
    int coll;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    repeat (2) @(negedge clock);
    check_idle("reset");
    reset = 1'b0;
    next_cycle();

    // Fill the whole memory so every later read has a defined expectation.
    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);

    // Single beat.
    preload(4, 32'hDEAD_BEEF);
    do_txn(32'h10, 0, -1, 1);

    // Four-beat burst, next request accepted in the return cycle.
    preload(8, 32'h11); preload(9, 32'h22); preload(10, 32'h33); preload(11, 32'h44);
    do_txn(32'h20, 3, -1, 0);

    // Wrap from the last word to word 0, then upper-bit aliasing.
    preload(1023, 32'hA); preload(0, 32'hB);
    do_txn(32'hFFC, 1, -1, 1);
    do_txn(32'h8000_0010, 0, -1, 1);

    // ICache-style back-to-back single beats.
    do_txn(32'h10, 0, -1, 1);
    do_txn(32'h24, 0, -1, 1);

    // Write collision on beat 2, then re-read the same region.
    do_txn(32'h100, 5, 2, 1);
    do_txn(32'h100, 5, -1, 1);

    // Reset while beat 2 of an 8-beat burst is on the outputs.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_len   = 8'd7;
    for (int c = 1; c <= L + 3; c++) next_cycle();
    check("rst_beat2", bus.rsp_data, model_mem[18]);
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    next_cycle();
    check_idle("rst_mid");
    reset = 1'b0;
    next_cycle();
    check_idle("post_rst");
    do_txn(32'h40, 7, -1, 1);

    // Random bursts, some near the wrap point, some with collisions.
    for (int i = 0; i < 25; i++) begin
      addr = $urandom;
      if (i % 4 == 0) addr[11:2] = 10'(DEPTH - int'($urandom_range(1, 4)));
      len  = int'($urandom_range(0, 12));
      coll = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len)) : -1;
      do_txn(addr, len, coll, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
